// File: rtl/wfg_wb_master_pkg.sv
// Shared types and default constants for the Wishbone classic command master.
package wfg_wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int DEF_BUSW           = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wfg_wb_master.sv
// Single-outstanding command-to-Wishbone-classic master with a one-cycle response pulse.
// Optional ack timeout enabled by defining WFG_WB_MASTER_TIMEOUT_EN.
import wfg_wb_master_pkg::*;

module wfg_wb_master #(
    parameter int BUSW           = DEF_BUSW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            io_wbs_clk,
    input  logic            io_wbs_rst,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [BUSW-1:0] cmd_adr_i,
    input  logic [BUSW-1:0] cmd_dat_i,

    output logic            rsp_valid_o,
    output logic [BUSW-1:0] rsp_dat_o,
    output logic            rsp_err_o,

    output logic [BUSW-1:0] io_wbm_adr_o,
    output logic [BUSW-1:0] io_wbm_datwr_o,
    input  logic [BUSW-1:0] io_wbm_datrd_i,
    output logic            io_wbm_we_o,
    output logic            io_wbm_stb_o,
    output logic            io_wbm_cyc_o,
    input  logic            io_wbm_ack_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wfg_wb_master: TIMEOUT_CYCLES must be at least 1");
    end

    wb_state_e       state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [BUSW-1:0] adr_q, adr_d;
    logic [BUSW-1:0] datwr_q, datwr_d;
    logic [BUSW-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WFG_WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        datwr_d   = datwr_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
        cnt_d     = '0;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    datwr_d = cmd_we_i ? cmd_dat_i : '0;
                end
            end

            BUS: begin
                // An ack always takes priority over a timeout expiring in the same cycle.
                if (io_wbm_ack_i) begin
                    state_d   = RESP;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rsp_dat_d = we_q ? '0 : io_wbm_datrd_i;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
                    rsp_err_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            datwr_q   <= '0;
            rsp_dat_q <= '0;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            datwr_q   <= datwr_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign cmd_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_dat_o      = rsp_dat_q;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
    assign rsp_err_o      = rsp_err_q;
`else
    assign rsp_err_o      = 1'b0;
`endif

    assign io_wbm_adr_o   = adr_q;
    assign io_wbm_datwr_o = datwr_q;
    assign io_wbm_we_o    = we_q;
    assign io_wbm_stb_o   = stb_q;
    assign io_wbm_cyc_o   = cyc_q;

endmodule

// File: tb/tb_wfg_wb_master.sv
// Randomized self-checking bench for wfg_wb_master against a memory-backed slave model.
`timescale 1ns/1ps

module tb_wfg_wb_master;

    localparam int BUSW = 32;
    localparam int TO   = 8;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [BUSW-1:0] cmd_adr_i, cmd_dat_i;
    logic            rsp_valid_o, rsp_err_o;
    logic [BUSW-1:0] rsp_dat_o;
    logic [BUSW-1:0] io_wbm_adr_o, io_wbm_datwr_o, io_wbm_datrd_i;
    logic            io_wbm_we_o, io_wbm_stb_o, io_wbm_cyc_o, io_wbm_ack_i;

    wfg_wb_master #(.BUSW(BUSW), .TIMEOUT_CYCLES(TO)) dut (
        .io_wbs_clk     (clk),
        .io_wbs_rst     (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_dat_i      (cmd_dat_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_dat_o      (rsp_dat_o),
        .rsp_err_o      (rsp_err_o),
        .io_wbm_adr_o   (io_wbm_adr_o),
        .io_wbm_datwr_o (io_wbm_datwr_o),
        .io_wbm_datrd_i (io_wbm_datrd_i),
        .io_wbm_we_o    (io_wbm_we_o),
        .io_wbm_stb_o   (io_wbm_stb_o),
        .io_wbm_cyc_o   (io_wbm_cyc_o),
        .io_wbm_ack_i   (io_wbm_ack_i)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc_cnt = 0;
    int rsp_seen = 0;
    int rsp_exp  = 0;
    logic [BUSW-1:0] last_rsp = '0;
    logic [BUSW-1:0] mem [bit [31:0]];

    always @(posedge clk) begin
        cyc_cnt++;
        if (rsp_valid_o) rsp_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got running, expected finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One command through the master; entered and left at a negedge with the DUT idle.
    task automatic transact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int delay, output int acc_cycle);
        logic [31:0] exp_rd;
        logic [31:0] exp_dat;
        bit          to;
        int          last;
        if (!we && !mem.exists(adr)) mem[adr] = $urandom;
        exp_rd = mem.exists(adr) ? mem[adr] : 32'h0;
        to     = TO_EN && (delay >= TO);
        last   = to ? TO - 1 : delay;

        check("ready_before_cmd", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        acc_cycle   = cyc_cnt;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'($urandom);
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;

        for (int n = 0; n <= last; n++) begin
            check("bus_cyc_stb", {io_wbm_cyc_o, io_wbm_stb_o}, 2'b11);
            check("bus_adr", io_wbm_adr_o, adr);
            check("bus_we", io_wbm_we_o, we);
            check("bus_datwr", io_wbm_datwr_o, we ? dat : 32'h0);
            check("bus_ready_low", cmd_ready_o, 0);
            check("bus_no_rsp", rsp_valid_o, 0);
            io_wbm_ack_i   = (n == delay);
            io_wbm_datrd_i = (n == delay && !we) ? exp_rd : $urandom;
            @(negedge clk);
        end
        io_wbm_ack_i   = 1'b0;
        io_wbm_datrd_i = $urandom;

        if (we) mem[adr] = dat;
        exp_dat  = (we || to) ? 32'h0 : exp_rd;
        last_rsp = exp_dat;
        rsp_exp++;
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_cyc_dropped", {io_wbm_cyc_o, io_wbm_stb_o}, 2'b00);
        check("rsp_dat", rsp_dat_o, exp_dat);
        check("rsp_err", rsp_err_o, to);
        check("rsp_ready_low", cmd_ready_o, 0);
        @(negedge clk);
        check("rsp_pulse_ends", rsp_valid_o, 0);
        check("ready_after_rsp", cmd_ready_o, 1);
        check("rsp_dat_held", rsp_dat_o, exp_dat);
        check("rsp_err_held", rsp_err_o, to);
    endtask

    initial begin
        int a0, a1, dummy;
        logic [31:0] b2b_we [4];
        logic [31:0] b2b_adr [4];
        logic [31:0] b2b_dat [4];
        logic [31:0] b2b_exp [4];
        int idx, accepts, rsps, overlap, cyc_rises;
        bit prev_cyc, accepting;

        rst            = 1'b1;
        cmd_valid_i    = 1'b0;
        cmd_we_i       = 1'b0;
        cmd_adr_i      = '0;
        cmd_dat_i      = '0;
        io_wbm_datrd_i = '0;
        io_wbm_ack_i   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cyc_stb_we", {io_wbm_cyc_o, io_wbm_stb_o, io_wbm_we_o}, 3'b000);
        check("rst_adr", io_wbm_adr_o, 0);
        check("rst_datwr", io_wbm_datwr_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o}, 2'b00);
        check("rst_rsp_dat", rsp_dat_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready_o, 1);

        // Directed write then reads with immediate ack and minimum spacing.
        transact(1'b1, 32'h10, 32'hDEADBEEF, 2, a0);
        mem[32'h4] = 32'h12345678;
        transact(1'b0, 32'h4, 32'h0, 0, a0);
        transact(1'b0, 32'h4, 32'h0, 0, a1);
        check("cmd_spacing", a1 - a0, 3);
        transact(1'b0, 32'h10, 32'h0, 1, a0);

        // Stray ack while idle.
        io_wbm_ack_i   = 1'b1;
        io_wbm_datrd_i = 32'hA5A5A5A5;
        repeat (2) begin
            @(negedge clk);
            check("stray_no_rsp", rsp_valid_o, 0);
            check("stray_idle", {cmd_ready_o, io_wbm_cyc_o}, 2'b10);
            check("stray_rsp_dat_held", rsp_dat_o, last_rsp);
        end
        io_wbm_ack_i = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            transact(1'($urandom), {27'h0, 3'($urandom_range(0, 7)), 2'b00},
                     $urandom, $urandom_range(0, 3), dummy);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during BUS aborts without a response.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h40;
        cmd_dat_i   = 32'hCAFEF00D;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("pre_abort_cyc", io_wbm_cyc_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cyc_stb", {io_wbm_cyc_o, io_wbm_stb_o}, 2'b00);
        check("abort_no_rsp", rsp_valid_o, 0);
        check("abort_rsp_dat", rsp_dat_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", cmd_ready_o, 1);
        check("abort_still_no_rsp", rsp_valid_o, 0);
        transact(1'b0, 32'h10, 32'h0, 1, dummy);

`ifdef WFG_WB_MASTER_TIMEOUT_EN
        transact(1'b0, 32'h4, 32'h0, 1000, dummy);
        transact(1'b0, 32'h4, 32'h0, TO - 1, dummy);
`endif

        // Back-to-back with cmd_valid held high and an immediately acking slave.
        for (int k = 0; k < 4; k++) begin
            b2b_we[k]  = (k % 2 == 0);
            b2b_adr[k] = 32'h20 + 32'(4 * (k / 2));
            b2b_dat[k] = (k % 2 == 0) ? $urandom : 32'h0;
        end
        for (int k = 0; k < 4; k++)
            b2b_exp[k] = (k % 2 == 0) ? 32'h0 : b2b_dat[k - 1];
        idx = 0; accepts = 0; rsps = 0; overlap = 0; cyc_rises = 0; prev_cyc = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = b2b_we[0][0];
        cmd_adr_i   = b2b_adr[0];
        cmd_dat_i   = b2b_dat[0];
        for (int c = 0; c < 16; c++) begin
            if (io_wbm_cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = io_wbm_cyc_o;
            if (cmd_ready_o && io_wbm_cyc_o) overlap++;
            if (rsp_valid_o && rsps < 4) begin
                check("b2b_rsp_dat", rsp_dat_o, b2b_exp[rsps]);
                rsps++;
                rsp_exp++;
            end
            io_wbm_ack_i = io_wbm_cyc_o;
            if (io_wbm_cyc_o && io_wbm_we_o) mem[io_wbm_adr_o] = io_wbm_datwr_o;
            io_wbm_datrd_i = mem.exists(io_wbm_adr_o) ? mem[io_wbm_adr_o] : $urandom;
            accepting = cmd_ready_o && cmd_valid_i;
            @(negedge clk);
            if (accepting) begin
                accepts++;
                idx++;
                if (idx < 4) begin
                    cmd_we_i  = b2b_we[idx][0];
                    cmd_adr_i = b2b_adr[idx];
                    cmd_dat_i = b2b_dat[idx];
                end else begin
                    cmd_valid_i = 1'b0;
                end
            end
        end
        io_wbm_ack_i = 1'b0;
        check("b2b_accepts", accepts, 4);
        check("b2b_cyc_bursts", cyc_rises, 4);
        check("b2b_overlap", overlap, 0);
        check("b2b_rsps", rsps, 4);

        repeat (2) @(negedge clk);
        check("rsp_pulse_count", rsp_seen, rsp_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
